bus_dev_endpoint: RTL

Device-side endpoint for the parallel bus: the peer of the bus controller's pndng/pop/D_pop and push/D_push lines for one driver slot. It buffers packets written by local logic in a TX FIFO and presents them to the bus via pndng/D_pop; the bus consumes them with pop. It receives bus pushes into an ID-filtered RX FIFO, which local logic drains. Sticky error flags and a drop counter support checks and coverage.

---
 rtl/bus_dev_endpoint_if.sv | 35 +++
 rtl/bus_dev_endpoint.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bus_dev_endpoint_if.sv
// ---------------------------------------------------------------------------
// bus_dev_endpoint_if
// Parallel-bus lines between the bus controller and one device driver slot.
//   pndng   device -> controller : device has a packet waiting
//   D_pop   device -> controller : packet at the head of the device TX queue
//   pop     controller -> device : controller consumes D_pop this cycle
//   push    controller -> device : controller delivers D_push this cycle
//   D_push  controller -> device : delivered packet
// Modports: slave = device endpoint side, master = controller side.
// ---------------------------------------------------------------------------
interface bus_dev_endpoint_if #(
    parameter int pckg_sz = 16
);
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;

    modport slave (
        output pndng,
        output D_pop,
        input  pop,
        input  push,
        input  D_push
    );

    modport master (
        input  pndng,
        input  D_pop,
        output pop,
        output push,
        output D_push
    );
endinterface

// File: rtl/bus_dev_endpoint.sv
// ---------------------------------------------------------------------------
// bus_dev_endpoint
// Device-side endpoint for the parallel bus. Local logic writes packets into
// a TX FIFO that the bus drains through pndng/D_pop/pop; bus pushes are
// ID-filtered into an RX FIFO that local logic drains. Both FIFOs are
// first-word-fall-through. Sticky error flags and a saturating drop counter
// report refused or filtered traffic.
// Ports:
//   clock, reset          clock (rising edge), asynchronous active-low reset
//   tx_wr, tx_data        local TX write strobe and packet
//   tx_full, tx_count     TX FIFO status
//   rx_valid, rx_data     RX FIFO head (FWFT) and non-empty flag
//   rx_rd, rx_count       local RX read strobe and RX occupancy
//   err_clr               synchronous clear of sticky flags and drop_cnt
//   tx_ovf, rx_ovf        sticky: refused tx_wr / refused matching push
//   pop_unf               sticky: pop while nothing pending
//   drop_cnt              pushes discarded by the ID filter (saturating)
//   bus                   controller-facing pndng/D_pop/pop/push/D_push
// ---------------------------------------------------------------------------
module bus_dev_endpoint #(
    parameter int         pckg_sz  = 16,
    parameter int         depth    = 8,
    parameter logic [7:0] dev_id   = 8'h00,
    parameter logic [7:0] bcast_id = 8'hFF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tx_wr,
    input  logic [pckg_sz-1:0]         tx_data,
    output logic                       tx_full,
    output logic [$clog2(depth):0]     tx_count,
    output logic                       rx_valid,
    output logic [pckg_sz-1:0]         rx_data,
    input  logic                       rx_rd,
    output logic [$clog2(depth):0]     rx_count,
    input  logic                       err_clr,
    output logic                       tx_ovf,
    output logic                       rx_ovf,
    output logic                       pop_unf,
    output logic [7:0]                 drop_cnt,
    bus_dev_endpoint_if.slave          bus
);
    localparam int              AW      = $clog2(depth);
    localparam int              CW      = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(depth);

    // Storage: plain arrays, read combinationally for first-word-fall-through.
    logic [pckg_sz-1:0] tx_mem_q [depth];
    logic [pckg_sz-1:0] rx_mem_q [depth];

    logic [AW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, pop_unf_q, pop_unf_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic tx_pop_ok, tx_wr_ok, rx_rd_ok, rx_push_ok, id_match;

    // A full FIFO still accepts a write when its head leaves in the same cycle.
    assign tx_pop_ok  = bus.pop && (tx_count_q != '0);
    assign tx_wr_ok   = tx_wr && ((tx_count_q < DEPTH_C) || tx_pop_ok);

    assign id_match   = (bus.D_push[pckg_sz-1 -: 8] == dev_id) ||
                        (bus.D_push[pckg_sz-1 -: 8] == bcast_id);
    assign rx_rd_ok   = rx_rd && (rx_count_q != '0);
    assign rx_push_ok = bus.push && id_match && ((rx_count_q < DEPTH_C) || rx_rd_ok);

    always_comb begin
        tx_count_d = tx_count_q;
        case ({tx_wr_ok, tx_pop_ok})
            2'b10:   tx_count_d = tx_count_q + 1'b1;
            2'b01:   tx_count_d = tx_count_q - 1'b1;
            default: tx_count_d = tx_count_q;
        endcase

        rx_count_d = rx_count_q;
        case ({rx_push_ok, rx_rd_ok})
            2'b10:   rx_count_d = rx_count_q + 1'b1;
            2'b01:   rx_count_d = rx_count_q - 1'b1;
            default: rx_count_d = rx_count_q;
        endcase

        // Clear first, then let a same-cycle event win.
        tx_ovf_d   = err_clr ? 1'b0 : tx_ovf_q;
        rx_ovf_d   = err_clr ? 1'b0 : rx_ovf_q;
        pop_unf_d  = err_clr ? 1'b0 : pop_unf_q;
        drop_cnt_d = err_clr ? 8'd0 : drop_cnt_q;
        if (tx_wr && !tx_wr_ok)
            tx_ovf_d = 1'b1;
        if (bus.push && id_match && !rx_push_ok)
            rx_ovf_d = 1'b1;
        if (bus.pop && (tx_count_q == '0))
            pop_unf_d = 1'b1;
        if (bus.push && !id_match && (drop_cnt_d != 8'hFF))
            drop_cnt_d = drop_cnt_d + 8'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_count_q <= '0;
            rx_count_q <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            pop_unf_q  <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            if (tx_wr_ok)   tx_wptr_q <= tx_wptr_q + 1'b1;
            if (tx_pop_ok)  tx_rptr_q <= tx_rptr_q + 1'b1;
            if (rx_push_ok) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_rd_ok)   rx_rptr_q <= rx_rptr_q + 1'b1;
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
            pop_unf_q  <= pop_unf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: every read is masked by the (reset) count.
    always_ff @(posedge clock) begin
        if (tx_wr_ok)   tx_mem_q[tx_wptr_q] <= tx_data;
        if (rx_push_ok) rx_mem_q[rx_wptr_q] <= bus.D_push;
    end

    assign bus.pndng = (tx_count_q != '0);
    assign bus.D_pop = (tx_count_q != '0) ? tx_mem_q[tx_rptr_q] : '0;
    assign tx_full   = (tx_count_q == DEPTH_C);
    assign tx_count  = tx_count_q;

    assign rx_valid  = (rx_count_q != '0);
    assign rx_data   = (rx_count_q != '0) ? rx_mem_q[rx_rptr_q] : '0;
    assign rx_count  = rx_count_q;

    assign tx_ovf    = tx_ovf_q;
    assign rx_ovf    = rx_ovf_q;
    assign pop_unf   = pop_unf_q;
    assign drop_cnt  = drop_cnt_q;
endmodule
